// File: rtl/prio_encoder_rr_seq.sv
// prio_encoder_rr_seq
//   Registered N-input priority encoder with a valid/ready output handshake.
//   mode=0 : fixed priority, highest set index wins.
//   mode=1 : round-robin, the last accepted index drops to lowest priority.
//
// Optional build macro: PRIO_ENC_GRANT_CNT_EN
//   When defined, a 16-bit saturating grant_count output counts accepted
//   handshakes. When undefined, the port and counter do not exist.
//
// Handshake: valid=1 means encoded_out/grant_onehot hold a result that the
// consumer has not yet taken. A transfer happens on a rising clk edge where
// valid && ready. While valid=1 and ready=0 the result is frozen and all
// request inputs are ignored. ready while valid=0 has no effect.

module prio_encoder_rr_seq #(
  parameter  int N = 8,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         mode,
  input  logic [N-1:0] data_in,
  input  logic         ready,
  output logic [W-1:0] encoded_out,
  output logic         valid,
  output logic [N-1:0] grant_onehot
`ifdef PRIO_ENC_GRANT_CNT_EN
  ,
  output logic [15:0]  grant_count
`endif
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t         state_q;
  state_t         state_d;

  logic [W-1:0]   enc_q;
  logic [W-1:0]   ptr_q;

  logic           any_req;
  logic           load;
  logic           accept;
  logic [W-1:0]   eff_ptr;

  logic [W-1:0]   fixed_sel;
  logic [W-1:0]   rr_sel;
  logic           rr_found;
  logic [W-1:0]   sel;

  int             rr_start;
  int             rr_pos;
  logic [W-1:0]   rr_idx;

  // Handshake and load qualification.
  always_comb begin
    any_req = |data_in;
    accept  = (state_q == HOLD) && ready;
    load    = enable && any_req && ((state_q == IDLE) || ready);
    // When a result is being accepted in this very cycle, the index leaving
    // is already the "last granted" one, so a back-to-back round-robin load
    // must search relative to it rather than the stale pointer register.
    eff_ptr = accept ? enc_q : ptr_q;
  end

  // Fixed priority: the highest set bit wins (later loop iterations override).
  always_comb begin
    fixed_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (data_in[i]) begin
        fixed_sel = W'(i);
      end
    end
  end

  // Round-robin: search eff_ptr-1, eff_ptr-2, ... wrapping through N-1 down
  // to eff_ptr; the first set bit in that order wins. Wrap is done
  // explicitly so non power-of-two N never yields an index >= N.
  always_comb begin
    rr_sel   = '0;
    rr_found = 1'b0;
    rr_pos   = 0;
    rr_idx   = '0;
    rr_start = (eff_ptr == '0) ? (N - 1) : (int'(eff_ptr) - 1);
    for (int k = 0; k < N; k++) begin
      rr_pos = (rr_start >= k) ? (rr_start - k) : (rr_start + N - k);
      rr_idx = W'(rr_pos);
      if (!rr_found && data_in[rr_idx]) begin
        rr_found = 1'b1;
        rr_sel   = rr_idx;
      end
    end
  end

  // Mode is only consulted here, so it only matters at a load edge.
  always_comb begin
    sel = mode ? rr_sel : fixed_sel;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: IDLE waits for a load, HOLD waits for ready and either
  // reloads (back-to-back, no bubble) or drains to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (ready) begin
          state_d = load ? HOLD : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Result register and round-robin pointer. encoded_out keeps its last
  // value after a drain; only a new load changes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      enc_q <= '0;
      ptr_q <= '0;
    end else begin
      if (load) begin
        enc_q <= sel;
      end
      if (accept) begin
        ptr_q <= enc_q;
      end
    end
  end

  // Output view of the registered state.
  always_comb begin
    valid        = (state_q == HOLD);
    encoded_out  = enc_q;
    grant_onehot = valid ? (N'(1) << enc_q) : '0;
  end

`ifdef PRIO_ENC_GRANT_CNT_EN
  logic [15:0] cnt_q;

  // Saturating count of accepted handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (accept && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign grant_count = cnt_q;
`endif

endmodule
